// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART command frame parser.
package uart_cmd_parser_pkg;

  // Frame assembly states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DHI  = 3'd2,
    ST_DLO  = 3'd3,
    ST_CSUM = 3'd4
  } state_t;

  // Default frame start byte.
  localparam logic [7:0] HEADER_DEF = 8'h55;

  // 8-bit checksum over the payload bytes, carry discarded; HEADER is not included.
  function automatic logic [7:0] csum8(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
    return a + b + c;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input and register-write output bundle of the command parser.
//
// Handshake: rx_done is a one-cycle strobe with no back-pressure; rx_byte is
// meaningful only in that cycle. wr_en, csum_err and timeout_err are one-cycle
// result strobes with no ready; wr_addr/wr_data hold the last accepted frame.
interface uart_cmd_parser_if;
  import uart_cmd_parser_pkg::*;

  logic [7:0]  rx_byte;
  logic        rx_done;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        csum_err;
  logic        timeout_err;
  logic        busy;
  state_t      dbg_state;

  // Byte source side (UART receiver / testbench).
  modport master (
    output rx_byte, rx_done,
    input  wr_en, wr_addr, wr_data, csum_err, timeout_err, busy, dbg_state
  );

  // Parser side.
  modport slave (
    input  rx_byte, rx_done,
    output wr_en, wr_addr, wr_data, csum_err, timeout_err, busy, dbg_state
  );
endinterface

// File: rtl/uart_cmd_parser_timeout.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear and
// raises a one-cycle expire pulse when the terminal count is reached without
// a clear in the same cycle (a clear always wins).
module uart_byte_timeout #(
  parameter int TIMEOUT_CYC = 43400,
  parameter int TO_W        = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_W-1:0] TERM = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] cnt;

  // Terminal count reached while counting and not being cleared.
  assign expire = en && !clr && (cnt == TERM);

  // Counter: cleared by clr or on expiry, otherwise advances while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || expire) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte command frames (HEADER, ADDR, DATA_HI, DATA_LO, CSUM) from
// the UART receiver byte stream and issues one register-write strobe per valid
// frame, reporting checksum mismatches and inter-byte timeouts.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter logic [7:0] HEADER      = HEADER_DEF,
  parameter int         TIMEOUT_CYC = 43400,
  parameter int         TO_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_cmd_parser_if.slave  bus
);

  state_t      state_q, state_d;
  logic [7:0]  addr_r, dhi_r, dlo_r;
  logic [7:0]  sum;
  logic        frame_ok, frame_bad;
  logic        expire;
  logic        to_clr;

  assign sum    = csum8(addr_r, dhi_r, dlo_r);
  assign to_clr = bus.rx_done || (state_q == ST_IDLE);

  uart_byte_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (to_clr),
    .en     (state_q != ST_IDLE),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and frame verdict; a received byte takes precedence over expiry.
  always_comb begin
    state_d   = state_q;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (bus.rx_done) begin
      unique case (state_q)
        ST_IDLE: if (bus.rx_byte == HEADER) state_d = ST_ADDR;
        ST_ADDR: state_d = ST_DHI;
        ST_DHI:  state_d = ST_DLO;
        ST_DLO:  state_d = ST_CSUM;
        ST_CSUM: begin
          state_d = ST_IDLE;
          if (bus.rx_byte == sum) frame_ok  = 1'b1;
          else                    frame_bad = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (expire) begin
      state_d = ST_IDLE;
    end
  end

  // Payload byte capture; a HEADER value mid-frame is ordinary data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= '0;
      dhi_r  <= '0;
      dlo_r  <= '0;
    end else if (bus.rx_done) begin
      case (state_q)
        ST_ADDR: addr_r <= bus.rx_byte;
        ST_DHI:  dhi_r  <= bus.rx_byte;
        ST_DLO:  dlo_r  <= bus.rx_byte;
        default: ;
      endcase
    end
  end

  // Registered result strobes and held write address/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wr_en       <= 1'b0;
      bus.csum_err    <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.wr_addr     <= '0;
      bus.wr_data     <= '0;
    end else begin
      bus.wr_en       <= frame_ok;
      bus.csum_err    <= frame_bad;
      bus.timeout_err <= expire;
      if (frame_ok) begin
        bus.wr_addr <= addr_r;
        bus.wr_data <= {dhi_r, dlo_r};
      end
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: expected result events are queued as
// stimulus is issued; a negedge monitor pops and compares every strobe.
module tb_uart_cmd_parser;
  import uart_cmd_parser_pkg::*;

  localparam int TO_CYC = 64;
  localparam logic [1:0] K_WR = 2'd1, K_CS = 2'd2, K_TO = 2'd3;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  // Event word: {kind[1:0], wr_addr[7:0], wr_data[15:0]}
  logic [25:0] exp_q[$];

  uart_cmd_parser_if bus_if ();

  uart_cmd_parser #(
    .HEADER      (8'h55),
    .TIMEOUT_CYC (TO_CYC),
    .TO_W        (16)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drivers: called at a negedge; consecutive calls give back-to-back rx_done.
  task automatic send_byte(input logic [7:0] b);
    bus_if.rx_byte = b;
    bus_if.rx_done = 1'b1;
    @(negedge clk);
    bus_if.rx_done = 1'b0;
    bus_if.rx_byte = $urandom_range(0, 255);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [7:0] a, input logic [15:0] d);
    exp_q.push_back({k, a, d});
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    idle(2);
    check({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [25:0] exp_ev, got_ev;
    logic [1:0]  k;
    if (rst_n && (bus_if.wr_en || bus_if.csum_err || bus_if.timeout_err)) begin
      n_checks++;
      if ((32'(bus_if.wr_en) + 32'(bus_if.csum_err) + 32'(bus_if.timeout_err)) > 1) begin
        n_fail++;
        $display("FAIL strobe_excl: wr_en=%b csum_err=%b timeout_err=%b required one-hot",
                 bus_if.wr_en, bus_if.csum_err, bus_if.timeout_err);
      end
      k = bus_if.wr_en ? K_WR : (bus_if.csum_err ? K_CS : K_TO);
      got_ev = {k, bus_if.wr_addr, bus_if.wr_data};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got event %h with nothing expected", got_ev);
      end else begin
        exp_ev = exp_q.pop_front();
        if (got_ev !== exp_ev) begin
          n_fail++;
          $display("FAIL event: got %h expected %h", got_ev, exp_ev);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    check({name, "_wr_en"}, 32'(bus_if.wr_en), 0);
    check({name, "_wr_addr"}, 32'(bus_if.wr_addr), 0);
    check({name, "_wr_data"}, 32'(bus_if.wr_data), 0);
    check({name, "_csum_err"}, 32'(bus_if.csum_err), 0);
    check({name, "_timeout_err"}, 32'(bus_if.timeout_err), 0);
    check({name, "_busy"}, 32'(bus_if.busy), 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus_if.rx_byte = '0;
    bus_if.rx_done = 1'b0;
    rst_n = 1'b0;
    idle(3);
    check_idle_outputs("reset");
    check("reset_state", 32'(bus_if.dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    idle(2);

    // 1: valid frame, 0x12+0xAB+0xCD = 0x18A -> 0x8A
    expect_ev(K_WR, 8'h12, 16'hABCD);
    send_byte(8'h55); send_byte(8'h12); send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h8A);
    wait_drain("t1");

    // 2: bad checksum, address/data keep the previous frame
    expect_ev(K_CS, 8'h12, 16'hABCD);
    send_byte(8'h55); send_byte(8'h12); send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h8B);
    wait_drain("t2");

    // 3: junk before header is dropped; 1+2+3 = 6
    expect_ev(K_WR, 8'h01, 16'h0203);
    send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h06);
    wait_drain("t3");

    // 4: inter-byte timeout, then a fresh frame is accepted
    send_byte(8'h55); send_byte(8'h12);
    check("t4_busy_mid", 32'(bus_if.busy), 1);
    expect_ev(K_TO, 8'h01, 16'h0203);
    idle(TO_CYC + 4);
    check("t4_busy_after_to", 32'(bus_if.busy), 0);
    wait_drain("t4a");
    expect_ev(K_WR, 8'h01, 16'h0000);
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h01);
    wait_drain("t4b");

    // 5: rx_done exactly at terminal count wins over the timeout
    expect_ev(K_WR, 8'h12, 16'hABCD);
    send_byte(8'h55); send_byte(8'h12);
    idle(TO_CYC - 1);
    send_byte(8'hAB);
    idle(TO_CYC - 1);
    send_byte(8'hCD);
    send_byte(8'h8A);
    wait_drain("t5");

    // Back-to-back frames, second header straight after the checksum
    expect_ev(K_WR, 8'h20, 16'h0102);
    expect_ev(K_WR, 8'h55, 16'h5555);
    send_byte(8'h55); send_byte(8'h20); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h23);
    send_byte(8'h55); send_byte(8'h55); send_byte(8'h55); send_byte(8'h55);
    send_byte(8'hFF);
    wait_drain("b2b");

    // 6: reset mid-frame, then 0x34+0x10+0x20 = 0x64
    send_byte(8'h55); send_byte(8'h12); send_byte(8'hAB);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t6_reset");
    check("t6_state", 32'(bus_if.dbg_state), 32'(ST_IDLE));
    idle(2);
    rst_n = 1'b1;
    idle(2);
    expect_ev(K_WR, 8'h34, 16'h1020);
    send_byte(8'h55); send_byte(8'h34); send_byte(8'h10); send_byte(8'h20);
    send_byte(8'h64);
    wait_drain("t6");
    check("final_busy", 32'(bus_if.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
